// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port main memory: fixed priority to
// requester 0, a starvation bound for requester 1, registered memory command.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic                  force1;
  logic                  acc0;
  logic                  acc1;
  logic [1:0]            rvalid_vec;

  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_id_q, s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_id_q, s2_id_d;

  // Requester 1 only overrides requester 0 once it has waited LIMIT cycles.
  assign force1 = r1_req && (starve_cnt_q >= LIMIT);
  assign r1_gnt = r1_req && (!r0_req || force1);
  assign r0_gnt = r0_req && !force1;
  assign acc0   = r0_req && r0_gnt;
  assign acc1   = r1_req && r1_gnt;

  always_comb begin
    starve_cnt_d  = starve_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_data_in_d = mem_data_in_q;
    s1_valid_d    = 1'b0;
    s1_id_d       = s1_id_q;
    s2_valid_d    = s1_valid_q;
    s2_id_d       = s1_id_q;

    if (!r1_req || acc1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    if (acc1) begin
      mem_addr_d    = r1_addr;
      mem_we_d      = r1_we;
      mem_data_in_d = r1_wdata;
      s1_valid_d    = !r1_we;
      s1_id_d       = 1'b1;
    end else if (acc0) begin
      mem_addr_d    = r0_addr;
      mem_we_d      = r0_we;
      mem_data_in_d = r0_wdata;
      s1_valid_d    = !r0_we;
      s1_id_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q  <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_data_in_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_id_q       <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_data_in_q <= mem_data_in_d;
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      s2_valid_q    <= s2_valid_d;
      s2_id_q       <= s2_id_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_data_in = mem_data_in_q;

  // Stage 2 lines up with the cycle the memory word appears on mem_data_out.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
    assign rvalid_vec[gi] = s2_valid_q && (s2_id_q == 1'(gi));
  end

  assign r0_rvalid = rvalid_vec[0];
  assign r1_rvalid = rvalid_vec[1];
  assign r0_rdata  = mem_data_out;
  assign r1_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [11:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [11:0] r0_rdata, r1_rdata;
  logic [11:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_we;

  logic        pl_en;
  logic [11:0] pl_addr, pl_data;
  logic [11:0] mem_model [0:4095];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Synchronous memory: address sampled at the edge, data valid the next cycle.
  always @(posedge clk) begin
    if (pl_en) mem_model[pl_addr] <= pl_data;
    else if (mem_we) mem_model[mem_addr] <= mem_data_in;
    mem_data_out <= mem_model[mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive_idle();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    next_cycle();
    pl_en = 1; pl_addr = a; pl_data = d;
    next_cycle();
    pl_en = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive_idle();
    next_cycle();
    next_cycle();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we c%0d got=%0h exp=0", c, mem_we); end
      vectors++; if (mem_addr !== 12'h000) begin miscompares++; $display("FAIL rst_mem_addr c%0d got=%0h exp=0", c, mem_addr); end
      vectors++; if (mem_data_in !== 12'h000) begin miscompares++; $display("FAIL rst_mem_data_in c%0d got=%0h exp=0", c, mem_data_in); end
      vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL rst_rvalid c%0d got=%b exp=00", c, {r0_rvalid, r1_rvalid}); end
      vectors++; if ({r0_gnt, r1_gnt} !== 2'b00) begin miscompares++; $display("FAIL rst_gnt c%0d got=%b exp=00", c, {r0_gnt, r1_gnt}); end
      vectors++; if (dut.starve_cnt_q !== 8'd0) begin miscompares++; $display("FAIL rst_starve c%0d got=%0d exp=0", c, dut.starve_cnt_q); end
      next_cycle();
    end
  endtask

  task automatic test_r0_alone();
    preload(12'h010, 12'h000);
    // cycle 0: write 0xABC to 0x010
    next_cycle();
    r0_req = 1; r0_we = 1; r0_addr = 12'h010; r0_wdata = 12'hABC;
    settle();
    vectors++; if (r0_gnt !== 1'b1) begin miscompares++; $display("FAIL r0_wr_gnt got=%b exp=1", r0_gnt); end
    // cycle 1: read 0x010
    next_cycle();
    r0_we = 0;
    settle();
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL r0_wr_mem_we got=%b exp=1", mem_we); end
    vectors++; if (mem_addr !== 12'h010) begin miscompares++; $display("FAIL r0_wr_mem_addr got=%0h exp=10", mem_addr); end
    vectors++; if (mem_data_in !== 12'hABC) begin miscompares++; $display("FAIL r0_wr_mem_data got=%0h exp=abc", mem_data_in); end
    // cycle 2: read issued
    next_cycle();
    drive_idle();
    settle();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL r0_rd_mem_we got=%b exp=0", mem_we); end
    vectors++; if (mem_addr !== 12'h010) begin miscompares++; $display("FAIL r0_rd_mem_addr got=%0h exp=10", mem_addr); end
    vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL r0_rd_early_rvalid got=%b exp=00", {r0_rvalid, r1_rvalid}); end
    // cycle 3: data returns
    next_cycle();
    settle();
    vectors++; if (r0_rvalid !== 1'b1) begin miscompares++; $display("FAIL r0_rd_rvalid got=%b exp=1", r0_rvalid); end
    vectors++; if (r0_rdata !== 12'hABC) begin miscompares++; $display("FAIL r0_rd_rdata got=%0h exp=abc", r0_rdata); end
    vectors++; if (r1_rvalid !== 1'b0) begin miscompares++; $display("FAIL r0_rd_r1_rvalid got=%b exp=0", r1_rvalid); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL r0_rd_mem_we3 got=%b exp=0", mem_we); end
    // cycle 4: single pulse only
    next_cycle();
    settle();
    vectors++; if (r0_rvalid !== 1'b0) begin miscompares++; $display("FAIL r0_rd_pulse got=%b exp=0", r0_rvalid); end
  endtask

  task automatic test_starvation();
    logic [11:0] r0g_exp = 12'b0001_1110_1111;
    logic [11:0] r1g_exp = 12'b0010_0001_0000;
    logic [11:0] r0v_exp = 12'b0111_1011_1100;
    logic [11:0] r1v_exp = 12'b1000_0100_0000;
    preload(12'h020, 12'h444);
    preload(12'h030, 12'h333);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (c < 10) begin
        r0_req = 1; r0_we = 0; r0_addr = 12'h020;
        r1_req = 1; r1_we = 0; r1_addr = 12'h030;
      end else begin
        drive_idle();
      end
      settle();
      vectors++; if (r0_gnt !== r0g_exp[c]) begin miscompares++; $display("FAIL starve_r0_gnt c%0d got=%b exp=%b", c, r0_gnt, r0g_exp[c]); end
      vectors++; if (r1_gnt !== r1g_exp[c]) begin miscompares++; $display("FAIL starve_r1_gnt c%0d got=%b exp=%b", c, r1_gnt, r1g_exp[c]); end
      vectors++; if (r0_rvalid !== r0v_exp[c]) begin miscompares++; $display("FAIL starve_r0_rvalid c%0d got=%b exp=%b", c, r0_rvalid, r0v_exp[c]); end
      vectors++; if (r1_rvalid !== r1v_exp[c]) begin miscompares++; $display("FAIL starve_r1_rvalid c%0d got=%b exp=%b", c, r1_rvalid, r1v_exp[c]); end
      if (r1v_exp[c]) begin
        vectors++; if (r1_rdata !== 12'h333) begin miscompares++; $display("FAIL starve_r1_rdata c%0d got=%0h exp=333", c, r1_rdata); end
      end
      if (r0v_exp[c]) begin
        vectors++; if (r0_rdata !== 12'h444) begin miscompares++; $display("FAIL starve_r0_rdata c%0d got=%0h exp=444", c, r0_rdata); end
      end
    end
  endtask

  task automatic test_interleaved();
    preload(12'h005, 12'h111);
    preload(12'h006, 12'h222);
    next_cycle();
    r1_req = 1; r1_we = 0; r1_addr = 12'h005;
    settle();
    vectors++; if (r1_gnt !== 1'b1) begin miscompares++; $display("FAIL il_r1_gnt got=%b exp=1", r1_gnt); end
    next_cycle();
    r1_req = 0;
    r0_req = 1; r0_we = 0; r0_addr = 12'h006;
    settle();
    vectors++; if (r0_gnt !== 1'b1) begin miscompares++; $display("FAIL il_r0_gnt got=%b exp=1", r0_gnt); end
    next_cycle();
    drive_idle();
    settle();
    vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b01) begin miscompares++; $display("FAIL il_c2_rvalid got=%b exp=01", {r0_rvalid, r1_rvalid}); end
    vectors++; if (r1_rdata !== 12'h111) begin miscompares++; $display("FAIL il_c2_rdata got=%0h exp=111", r1_rdata); end
    next_cycle();
    settle();
    vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b10) begin miscompares++; $display("FAIL il_c3_rvalid got=%b exp=10", {r0_rvalid, r1_rvalid}); end
    vectors++; if (r0_rdata !== 12'h222) begin miscompares++; $display("FAIL il_c3_rdata got=%0h exp=222", r0_rdata); end
    next_cycle();
    settle();
    vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL il_c4_rvalid got=%b exp=00", {r0_rvalid, r1_rvalid}); end
  endtask

  task automatic test_reset_mid();
    // cycle 0: r0 read accepted, r1 waiting
    next_cycle();
    r0_req = 1; r0_we = 0; r0_addr = 12'h010;
    r1_req = 1; r1_we = 0; r1_addr = 12'h030;
    settle();
    vectors++; if (r0_gnt !== 1'b1) begin miscompares++; $display("FAIL rm_r0_gnt got=%b exp=1", r0_gnt); end
    // cycle 1: reset while a write would otherwise be accepted
    next_cycle();
    reset = 1;
    r0_we = 1; r0_addr = 12'h040; r0_wdata = 12'h5A5;
    next_cycle();
    reset = 0;
    drive_idle();
    settle();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rm_mem_we got=%b exp=0", mem_we); end
    vectors++; if (mem_addr !== 12'h000) begin miscompares++; $display("FAIL rm_mem_addr got=%0h exp=0", mem_addr); end
    vectors++; if (mem_data_in !== 12'h000) begin miscompares++; $display("FAIL rm_mem_data_in got=%0h exp=0", mem_data_in); end
    vectors++; if (dut.starve_cnt_q !== 8'd0) begin miscompares++; $display("FAIL rm_starve got=%0d exp=0", dut.starve_cnt_q); end
    for (int c = 2; c < 5; c++) begin
      vectors++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL rm_rvalid c%0d got=%b exp=00", c, {r0_rvalid, r1_rvalid}); end
      next_cycle();
      settle();
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      r0_req = 1; r0_we = 0; r0_addr = 12'h020;
      r1_req = 1; r1_we = 0; r1_addr = 12'h030;
      settle();
      vectors++; if ({r0_gnt, r1_gnt} !== 2'b10) begin miscompares++; $display("FAIL pri_gnt c%0d got=%b exp=10", c, {r0_gnt, r1_gnt}); end
      vectors++; if (dut.starve_cnt_q !== 8'(c)) begin miscompares++; $display("FAIL pri_starve c%0d got=%0d exp=%0d", c, dut.starve_cnt_q, c); end
    end
    next_cycle();
    r0_req = 0;
    settle();
    vectors++; if ({r0_gnt, r1_gnt} !== 2'b01) begin miscompares++; $display("FAIL pri_r1_win got=%b exp=01", {r0_gnt, r1_gnt}); end
    vectors++; if (dut.starve_cnt_q !== 8'd2) begin miscompares++; $display("FAIL pri_starve2 got=%0d exp=2", dut.starve_cnt_q); end
    next_cycle();
    drive_idle();
    settle();
    vectors++; if (dut.starve_cnt_q !== 8'd0) begin miscompares++; $display("FAIL pri_starve_clr got=%0d exp=0", dut.starve_cnt_q); end
    next_cycle();
    settle();
    vectors++; if (r1_rvalid !== 1'b1) begin miscompares++; $display("FAIL pri_r1_rvalid got=%b exp=1", r1_rvalid); end
    vectors++; if (r1_rdata !== 12'h333) begin miscompares++; $display("FAIL pri_r1_rdata got=%0h exp=333", r1_rdata); end
  endtask

  initial begin
    reset = 1;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    drive_idle();
    test_reset();
    test_r0_alone();
    test_starvation();
    test_interleaved();
    test_reset_mid();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 12-bit main memory between the core datapath (requester 0) and a second master (requester 1, the UART program loader or debug port). It accepts one access per clock through a valid/ready handshake, registers the memory command, and routes read data back to the requester that issued it. Requester 0 has fixed priority. A starvation counter bounds how long requester 1 can wait.

## Interface
- `ADDR_WIDTH`, default 12, memory address width.
- `DATA_WIDTH`, default 12, memory word width.
- `STARVE_LIMIT`, default 4, maximum consecutive denied cycles for requester 1 before it is forced through. Must be 1 to 255.

- `clk`  in  1  single clock. Every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `r0_req`, `r1_req`  in  1  access request. Address, write enable and write data must stay stable while the request is high and not yet accepted.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_WIDTH  access address.
- `r0_wdata`, `r1_wdata`  in  DATA_WIDTH  write data.
- `r0_gnt`, `r1_gnt`  out  1  combinational ready. Accept = `req` && `gnt` in the same cycle.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle pulse: read data is valid.
- `r0_rdata`, `r1_rdata`  out  DATA_WIDTH  direct pass-through of `mem_data_out`. Meaningful only when `rvalid` is high.
- `mem_addr`  out  ADDR_WIDTH  registered memory address.
- `mem_we`  out  1  registered memory write enable.
- `mem_data_in`  out  DATA_WIDTH  registered memory write data.
- `mem_data_out`  in  DATA_WIDTH  memory read data, valid one cycle after the address is presented.

## Operation
- Arbitration is combinational on the current `req` signals and `starve_cnt`:
  - `force1` = `r1_req` && (`starve_cnt` >= `STARVE_LIMIT`).
  - `r1_gnt` = `r1_req` && (!`r0_req` || `force1`).
  - `r0_gnt` = `r0_req` && !`force1`.
  - At most one grant is high per cycle.
- Starvation counter (8 bits):
  - Clears to 0 when `r1_req` is low or requester 1 is accepted.
  - Increments when `r1_req` && !`r1_gnt`.
  - Saturates at `STARVE_LIMIT`.
- On an accept in cycle T, the winner's address, write enable and write data load into `mem_addr`, `mem_we` and `mem_data_in` at the end of T.
- With no accept in a cycle:
  - `mem_we` loads 0.
  - `mem_addr` and `mem_data_in` hold their previous values.
- Read tracking uses a 2-stage tag pipeline: stage valid bit plus requester id.
  - Stage 1 loads on the accept of a read.
  - Stage 2 copies stage 1.
  - `rN_rvalid` = stage-2 valid && stage-2 id == N.
- Writes produce no `rvalid`.
- States are implicit: IDLE (no accept), ISSUE (command registered), RETURN (stage 2 valid). Reads can overlap fully, so the block sustains 1 access per cycle.
- Reset sets:
  - `mem_addr` = 0, `mem_we` = 0, `mem_data_in` = 0.
  - Both tag stages invalid.
  - `starve_cnt` = 0.
- After reset:
  - `gnt` outputs follow the arbitration equations immediately.
  - `rvalid` outputs are 0.
  - Reads in flight when reset asserted never return an `rvalid`.

## Timing
- Read accepted in cycle T:
  - `mem_*` is driven in T+1.
  - The memory samples at the end of T+1.
  - `rvalid` pulses for exactly cycle T+2, and `rdata` equals the memory word.
  - Read latency from accept to data is 2 cycles.
- Write accepted in T: `mem_we` = 1 during T+1 only, and memory commits at the end of T+1.
- Write to address A accepted in T, then read of A accepted in T+1: the read returns the new data in T+3.
- Back-to-back reads from alternating requesters return in order, one `rvalid` per cycle, on the correct port.
- Both `req` high with `starve_cnt` < `STARVE_LIMIT`: requester 0 wins.
- With `r0_req` held high continuously, requester 1 is accepted exactly once per `STARVE_LIMIT`+1 cycles.
- A requester that holds `req` high after being accepted issues a new access in the next cycle. Deasserting `req` is the requester's responsibility.

## Test plan
- Reset, then idle with no requests:
  - `mem_we` = 0, `mem_addr` = 0, `mem_data_in` = 0.
  - No `rvalid`.
  - `r0_gnt` = 0 and `r1_gnt` = 0.
- Requester 0 alone:
  - Stimulus: write 0xABC to address 0x010 in cycle 0, then read 0x010 in cycle 1.
  - Required: `mem_we` = 1 in cycle 1 only; `r0_rvalid` high in cycle 3 only with `r0_rdata` = 0xABC; `r1_rvalid` stays 0.
- Starvation with `STARVE_LIMIT` = 4:
  - Stimulus: both requesters hold reads continuously from cycle 0.
  - Required: r0 accepted in cycles 0-3, r1 accepted in cycle 4, then r0 in 5-8, r1 in 9. `r1_rvalid` pulses in cycles 6 and 11.
- Interleaved reads:
  - Stimulus: r1 reads 0x005 (holding 0x111) in cycle 0 with r0 idle; r0 reads 0x006 (holding 0x222) in cycle 1.
  - Required: `r1_rvalid` in cycle 2 with data 0x111; `r0_rvalid` in cycle 3 with data 0x222.
- Reset mid-operation:
  - Stimulus: r0 read accepted in cycle 0, `reset` high in cycle 1.
  - Required: no `rvalid` in cycle 2 or later; `mem_we` = 0 and `starve_cnt` = 0 after the reset edge.
- Priority without starvation:
  - Stimulus: `r1_req` high for 2 cycles while `r0_req` is also high, then `r0_req` drops.
  - Required: r1 accepted in the first cycle `r0_req` is low; `starve_cnt` back to 0 in the following cycle.
